kamikaze_execute_pipe: RTL and testbench

Registered, parametrised execute stage for the kamikaze RISC-V core, replacing the purely combinational execute/ALU.
- Implements the full RV32I integer ALU operation set at width XLEN.
- Adds a valid/ready handshake on both sides plus a pipeline flush.
- Optionally uses a serial (1 bit/cycle) shifter to save area.
- Sits between decode (upstream) and memory/writeback (downstream). Carries rd index, rd write-enable and PC alongside the result.

---
 rtl/kamikaze_execute_pipe.sv | 162 ++++++++++++++++
 tb/tb_kamikaze_execute_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kamikaze_execute_pipe.sv
// Registered RV32I execute stage. It has valid/ready handshakes on both sides and a flush input.
// Shifts use either a single-cycle barrel shifter or an iterative 1-bit/cycle shifter.
module kamikaze_execute_pipe #(
  parameter int XLEN         = 32,
  parameter bit SHIFT_SERIAL = 1'b0,
  parameter int PC_W         = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] alu_op1_i,
  input  logic [XLEN-1:0] alu_op2_i,
  input  logic [3:0]      alu_func_i,
  input  logic [4:0]      rf_rd_i,
  input  logic            rf_rd_we_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rf_rd_o,
  output logic            rf_rd_we_o,
  output logic [PC_W-1:0] pc_o
);
  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b1000;
  localparam logic [3:0] F_SLL  = 4'b0001;
  localparam logic [3:0] F_SLT  = 4'b0010;
  localparam logic [3:0] F_SLTU = 4'b0011;
  localparam logic [3:0] F_XOR  = 4'b0100;
  localparam logic [3:0] F_SRL  = 4'b0101;
  localparam logic [3:0] F_SRA  = 4'b1101;
  localparam logic [3:0] F_OR   = 4'b0110;
  localparam logic [3:0] F_AND  = 4'b0111;

  typedef enum logic [1:0] {S_EMPTY, S_SHIFT, S_FULL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   shreg_q, shreg_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic              sh_right_q, sh_right_d;
  logic              sh_arith_q, sh_arith_d;
  logic [4:0]        rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  logic [SH_W-1:0]   shamt;
  logic              is_shift;
  logic              accept;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   shift_step;

  assign shamt    = alu_op2_i[SH_W-1:0];
  assign is_shift = (alu_func_i == F_SLL) || (alu_func_i == F_SRL) || (alu_func_i == F_SRA);
  assign ready_o  = (state_q == S_EMPTY) || ((state_q == S_FULL) && ready_i);
  assign accept   = valid_i && ready_o && !flush_i;

  // With the serial shifter the barrel path is only reached for shamt==0, so it reduces to op1.
  always_comb begin
    alu_res = '0;
    case (alu_func_i)
      F_ADD:  alu_res = alu_op1_i + alu_op2_i;
      F_SUB:  alu_res = alu_op1_i - alu_op2_i;
      F_SLL:  alu_res = SHIFT_SERIAL ? alu_op1_i : (alu_op1_i << shamt);
      F_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_op1_i) < $signed(alu_op2_i))};
      F_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_op1_i < alu_op2_i)};
      F_XOR:  alu_res = alu_op1_i ^ alu_op2_i;
      F_SRL:  alu_res = SHIFT_SERIAL ? alu_op1_i : (alu_op1_i >> shamt);
      F_SRA:  alu_res = SHIFT_SERIAL ? alu_op1_i : $unsigned($signed(alu_op1_i) >>> shamt);
      F_OR:   alu_res = alu_op1_i | alu_op2_i;
      F_AND:  alu_res = alu_op1_i & alu_op2_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    shift_step = '0;
    if (sh_right_q) shift_step = {sh_arith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
    else            shift_step = {shreg_q[XLEN-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    sh_right_d = sh_right_q;
    sh_arith_d = sh_arith_q;
    rd_d       = rd_q;
    rd_we_d    = rd_we_q;
    pc_d       = pc_q;

    case (state_q)
      S_SHIFT: begin
        shreg_d = shift_step;
        cnt_d   = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) begin
          state_d  = S_FULL;
          result_d = shift_step;
        end
      end
      S_FULL: if (ready_i) state_d = S_EMPTY;
      default: ;
    endcase

    if (accept) begin
      rd_d    = rf_rd_i;
      rd_we_d = rf_rd_we_i && (rf_rd_i != 5'd0);
      pc_d    = pc_i;
      if (SHIFT_SERIAL && is_shift && (shamt != '0)) begin
        state_d    = S_SHIFT;
        shreg_d    = alu_op1_i;
        cnt_d      = shamt;
        sh_right_d = alu_func_i[2];
        sh_arith_d = alu_func_i[3];
      end else begin
        state_d  = S_FULL;
        result_d = alu_res;
      end
    end

    if (flush_i) begin
      state_d = S_EMPTY;
      rd_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_EMPTY;
      result_q   <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sh_right_q <= 1'b0;
      sh_arith_q <= 1'b0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sh_right_q <= sh_right_d;
      sh_arith_q <= sh_arith_d;
      rd_q       <= rd_d;
      rd_we_q    <= rd_we_d;
      pc_q       <= pc_d;
    end
  end

  assign valid_o    = (state_q == S_FULL);
  assign result_o   = result_q;
  assign rf_rd_o    = rd_q;
  assign rf_rd_we_o = rd_we_q;
  assign pc_o       = pc_q;

endmodule

// File: tb/tb_kamikaze_execute_pipe.sv
// Scoreboard bench for kamikaze_execute_pipe: one barrel-shifter instance (0) and one serial-shifter instance (1).
// Each instance has its own driver and its own monitor.
module tb_kamikaze_execute_pipe;
  localparam int XLEN = 32;
  localparam int PC_W = 32;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst[2], flush[2], vin[2], rdy_o[2], rdy_i[2], vout[2], we_i[2], we_o[2];
  logic [31:0] op1[2], op2[2], res[2], pc_i[2], pc_o[2];
  logic [3:0]  fn[2];
  logic [4:0]  rd_i[2], rd_o[2];

  exp_t q0[$], q1[$];
  int errors = 0, checks = 0;

  kamikaze_execute_pipe #(.XLEN(XLEN), .SHIFT_SERIAL(1'b0), .PC_W(PC_W)) u_bar (
    .clk_i(clk), .rst_i(rst[0]), .flush_i(flush[0]), .valid_i(vin[0]), .ready_o(rdy_o[0]),
    .alu_op1_i(op1[0]), .alu_op2_i(op2[0]), .alu_func_i(fn[0]), .rf_rd_i(rd_i[0]),
    .rf_rd_we_i(we_i[0]), .pc_i(pc_i[0]), .valid_o(vout[0]), .ready_i(rdy_i[0]),
    .result_o(res[0]), .rf_rd_o(rd_o[0]), .rf_rd_we_o(we_o[0]), .pc_o(pc_o[0]));

  kamikaze_execute_pipe #(.XLEN(XLEN), .SHIFT_SERIAL(1'b1), .PC_W(PC_W)) u_ser (
    .clk_i(clk), .rst_i(rst[1]), .flush_i(flush[1]), .valid_i(vin[1]), .ready_o(rdy_o[1]),
    .alu_op1_i(op1[1]), .alu_op2_i(op2[1]), .alu_func_i(fn[1]), .rf_rd_i(rd_i[1]),
    .rf_rd_we_i(we_i[1]), .pc_i(pc_i[1]), .valid_o(vout[1]), .ready_i(rdy_i[1]),
    .result_o(res[1]), .rf_rd_o(rd_o[1]), .rf_rd_we_o(we_o[1]), .pc_o(pc_o[1]));

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qpeek(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction
  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask
  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask
  task automatic qclear(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  // Reference ALU: evaluated directly from the RV32I operation definitions.
  function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic [31:0] r;
    sh = int'(b[4:0]);
    r  = a;
    case (f)
      4'h0: return a + b;
      4'h8: return a - b;
      4'h1: return a << sh;
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a ^ b;
      4'h5: return a >> sh;
      4'hD: begin repeat (sh) r = {r[31], r[31:1]}; return r; end
      4'h6: return a | b;
      4'h7: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_sh(input logic [3:0] f);
    return (f == 4'h1) || (f == 4'h5) || (f == 4'hD);
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic we, input logic [31:0] pc,
                       input logic rdy, input bit rnd, input int exp_wait);
    exp_t e;
    int w = 0;
    fn[d] = f; op1[d] = a; op2[d] = b; rd_i[d] = rd; we_i[d] = we; pc_i[d] = pc;
    vin[d] = 1'b1; rdy_i[d] = rdy;
    forever begin
      @(negedge clk);
      if (rdy_o[d] === 1'b1) break;
      w++;
      if (w > 100) begin chk("accept_timeout", d, 64'(w), 64'd0); break; end
      step();
      if (rnd) rdy_i[d] = ($urandom_range(0, 3) != 0);
    end
    if (w <= 100) begin
      e.res = model(f, a, b);
      e.rd  = rd;
      e.we  = we && (rd != 5'd0);
      e.pc  = pc;
      e.acc = cyc;
      e.lat = (d == 1 && is_sh(f) && b[4:0] != 5'd0) ? 1 + int'(b[4:0]) : 1;
      qpush(d, e);
    end
    if (exp_wait >= 0) chk("ready_wait", d, 64'(w), 64'(exp_wait));
    step();
    vin[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1; vin[d] = 1'b0; flush[d] = 1'b0; rdy_i[d] = 1'b0;
    @(negedge clk);
    qclear(d);
    step();
    rst[d] = 1'b0;
    @(negedge clk);
    chk("rst_valid", d, 64'(vout[d]), 64'd0);
    chk("rst_result", d, 64'(res[d]), 64'd0);
    chk("rst_rd", d, {58'd0, rd_o[d], we_o[d]}, 64'd0);
    chk("rst_pc", d, 64'(pc_o[d]), 64'd0);
    chk("rst_ready", d, 64'(rdy_o[d]), 64'd1);
    step();
  endtask

  task automatic do_flush(input int d, input int exp_rd);
    flush[d] = 1'b1; rdy_i[d] = 1'b0; vin[d] = 1'b1;
    fn[d] = 4'h0; op1[d] = $urandom; op2[d] = $urandom; rd_i[d] = 5'd12; we_i[d] = 1'b1;
    @(negedge clk);
    qclear(d);
    step();
    flush[d] = 1'b0; vin[d] = 1'b0;
    @(negedge clk);
    chk("flush_valid", d, 64'(vout[d]), 64'd0);
    chk("flush_we", d, 64'(we_o[d]), 64'd0);
    chk("flush_ready", d, 64'(rdy_o[d]), 64'd1);
    if (exp_rd >= 0) chk("flush_rd_kept", d, 64'(rd_o[d]), 64'(exp_rd));
    step();
  endtask

  task automatic monitor(input int d);
    exp_t e;
    bit seen = 0, hold = 0;
    logic [63:0] h0;
    logic [5:0]  h1;
    forever begin
      @(negedge clk);
      if (rst[d] === 1'b1 || flush[d] === 1'b1) begin seen = 0; hold = 0; continue; end
      if (hold) begin
        chk("hold_valid", d, 64'(vout[d]), 64'd1);
        chk("hold_res_pc", d, {res[d], pc_o[d]}, h0);
        chk("hold_rd_we", d, 64'({rd_o[d], we_o[d]}), 64'(h1));
      end
      hold = 0;
      if (vout[d] === 1'b1) begin
        if (qsize(d) == 0) chk("valid_unexpected", d, 64'(vout[d]), 64'd0);
        else begin
          e = qpeek(d);
          if (!seen) begin chk("latency", d, 64'(cyc - e.acc), 64'(e.lat)); seen = 1; end
          if (rdy_i[d] === 1'b1) begin
            chk("result", d, 64'(res[d]), 64'(e.res));
            chk("rd", d, 64'(rd_o[d]), 64'(e.rd));
            chk("rd_we", d, 64'(we_o[d]), 64'(e.we));
            chk("pc", d, 64'(pc_o[d]), 64'(e.pc));
            qpop(d);
            seen = 0;
          end else begin
            hold = 1;
            h0 = {res[d], pc_o[d]};
            h1 = {rd_o[d], we_o[d]};
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp[5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'h7FFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'hFFFF_FFFF;
    return ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
  endfunction

  task automatic driver(input int d);
    step();
    do_reset(d);
    issue(d, 4'h0, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1, 32'h100, 1'b1, 1'b0, 0);
    issue(d, 4'h8, 32'd3, 32'd5, 5'd6, 1'b1, 32'h104, 1'b1, 1'b0, 0);
    issue(d, 4'h2, 32'h8000_0000, 32'd1, 5'd7, 1'b1, 32'h108, 1'b1, 1'b0, 0);
    issue(d, 4'h3, 32'h8000_0000, 32'd1, 5'd8, 1'b1, 32'h10C, 1'b1, 1'b0, 0);
    issue(d, 4'hD, 32'h8000_0000, 32'd4, 5'd9, 1'b1, 32'h110, 1'b1, 1'b0, 0);
    issue(d, 4'h1, 32'h1, 32'd0, 5'd10, 1'b1, 32'h114, 1'b1, 1'b0, (d == 1) ? 4 : 0);
    repeat (2) step();
    issue(d, 4'h0, 32'h1234, 32'h0, 5'd11, 1'b1, 32'h118, 1'b0, 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", d, 64'(rdy_o[d]), 64'd0);
      step();
    end
    issue(d, 4'h4, 32'hF0, 32'hFF, 5'd12, 1'b1, 32'h11C, 1'b1, 1'b0, 0);
    issue(d, 4'h5, 32'hFFFF_FFFF, 32'd20, 5'd9, 1'b1, 32'h120, 1'b1, 1'b0, 0);
    repeat (3) step();
    do_flush(d, 9);
    issue(d, 4'h6, 32'hA, 32'h5, 5'd13, 1'b1, 32'h124, 1'b1, 1'b0, 0);
    issue(d, 4'hD, 32'h8000_0000, 32'd10, 5'd14, 1'b1, 32'h128, 1'b1, 1'b0, 0);
    repeat (2) step();
    do_reset(d);
    issue(d, 4'h0, 32'd7, 32'd8, 5'd15, 1'b1, 32'h12C, 1'b0, 1'b0, 0);
    step();
    do_reset(d);
    issue(d, 4'h0, 32'd1, 32'd1, 5'd0, 1'b1, 32'h130, 1'b1, 1'b0, 0);
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) begin rdy_i[d] = ($urandom_range(0, 3) != 0); step(); end
      if ($urandom_range(0, 19) == 0) do_flush(d, -1);
      else issue(d, 4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom), 1'($urandom),
                 $urandom, ($urandom_range(0, 3) != 0), 1'b1, -1);
    end
    rdy_i[d] = 1'b1;
    repeat (40) step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; flush[d] = 1'b0; vin[d] = 1'b0; rdy_i[d] = 1'b0; we_i[d] = 1'b0;
      op1[d] = '0; op2[d] = '0; fn[d] = '0; rd_i[d] = '0; pc_i[d] = '0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none
    fork
      driver(0);
      driver(1);
    join
    chk("drain", 0, 64'(qsize(0)), 64'd0);
    chk("drain", 1, 64'(qsize(1)), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
